// File: rtl/rv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
//   enc_op_e    : field-level request operation
//   enc_fmt_e   : instruction format selector for the field packer
//   enc_state_e : output-stage FSM states
//   pack_req_t  : payload handed to inst_field_pack
package rv_enc_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned OP_W     = 4;

  typedef enum logic [OP_W-1:0] {
    OP_R      = 4'd0,
    OP_I      = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_JAL    = 4'd5,
    OP_JALR   = 4'd6,
    OP_LUI    = 4'd7,
    OP_AUIPC  = 4'd8,
    OP_LI     = 4'd9,
    OP_NOP    = 4'd10
  } enc_op_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } enc_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ONE   = 2'd1,
    ST_FIRST = 2'd2
  } enc_state_e;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [XLEN-1:0] WORD_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [OPC_W-1:0]    opcode;
    enc_fmt_e            fmt;
    logic [FUNCT3_W-1:0] funct3;
    logic                alt;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [XLEN-1:0]     imm;
  } pack_req_t;

  // True when v equals the sign extension of its low 'bits' bits.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int unsigned bits);
    logic [XLEN-1:0] mask;
    mask = 32'hFFFF_FFFF << (bits - 1);
    return ((v & mask) == 32'd0) || ((v & mask) == mask);
  endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: places opcode, register fields and immediate bits
// into the RV32I R/I/S/B/U/J layouts.
//   req  : opcode, format, funct3, alt (bit 30), rd/rs1/rs2, full immediate
//   word : packed 32-bit instruction
module inst_field_pack
  import rv_enc_pkg::*;
(
  input  pack_req_t        req,
  output logic [XLEN-1:0]  word
);

  always_comb begin
    word = WORD_NOP;
    case (req.fmt)
      FMT_R: word = {1'b0, req.alt, 5'b0_0000, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      // alt lands on bit 30 (imm[10]); shift requests keep imm[10] clear
      FMT_I: word = {req.imm[11], req.imm[10] | req.alt, req.imm[9:0], req.rs1, req.funct3,
                     req.rd, req.opcode};
      FMT_S: word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
      FMT_B: word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3, req.imm[4:1],
                     req.imm[11], req.opcode};
      FMT_U: word = {req.imm[31:12], req.rd, req.opcode};
      FMT_J: word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
      default: word = WORD_NOP;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Field-level request -> RV32I instruction word encoder with a registered,
// backpressured output. LI expands to LUI+ADDI when the immediate does not
// fit 12 bits; illegal requests produce a NOP/EBREAK substitute with inst_err.
//   clk, reset_n              : clock, async active-low reset
//   req_valid/req_ready       : request handshake
//   req_op..req_imm           : request fields
//   inst_valid/inst_ready     : output handshake
//   inst_o, inst_last, inst_err : encoded word, last-of-request, illegal flag
module inst_encoder
  import rv_enc_pkg::*;
#(
  parameter bit LI_SPLIT   = 1'b1,
  parameter bit ERR_EBREAK = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [2:0]  req_funct3,
  input  logic        req_alt,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic        inst_last,
  output logic        inst_err
);

  localparam logic [XLEN-1:0] WORD_SUBST = ERR_EBREAK ? WORD_EBREAK : WORD_NOP;

  pack_req_t       pk;
  pack_req_t       pk_addi;
  logic [XLEN-1:0] word_pk;
  logic [XLEN-1:0] word_addi;
  logic [XLEN-1:0] first_word;
  logic            illegal;
  logic            split;
  logic            to_nop;
  logic            fit12;
  logic            fit13;
  logic            fit21;
  logic            lo_zero;
  logic            is_shift;
  logic [19:0]     li_hi;

  enc_state_e      state;
  enc_state_e      state_nxt;
  logic [XLEN-1:0] addi_q;
  logic [XLEN-1:0] addi_nxt;
  logic [XLEN-1:0] inst_nxt;
  logic            valid_nxt;
  logic            last_nxt;
  logic            err_nxt;
  logic            accept;

  inst_field_pack u_pack_main (.req(pk),      .word(word_pk));
  inst_field_pack u_pack_addi (.req(pk_addi), .word(word_addi));

  // Legality check and field selection for the first (or only) word.
  always_comb begin
    fit12    = fits_signed(req_imm, 12);
    fit13    = fits_signed(req_imm, 13);
    fit21    = fits_signed(req_imm, 21);
    lo_zero  = (req_imm[11:0] == 12'd0);
    // Rounds the upper half up when the low 12 bits will be sign-extended negative.
    li_hi    = req_imm[31:12] + 20'(req_imm[11]);
    is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    illegal  = 1'b0;
    split    = 1'b0;
    to_nop   = 1'b0;

    pk.opcode = OPC_OP_IMM;
    pk.fmt    = FMT_I;
    pk.funct3 = req_funct3;
    pk.alt    = 1'b0;
    pk.rd     = req_rd;
    pk.rs1    = req_rs1;
    pk.rs2    = req_rs2;
    pk.imm    = req_imm;

    case (enc_op_e'(req_op))
      OP_R: begin
        pk.opcode = OPC_OP;
        pk.fmt    = FMT_R;
        pk.alt    = req_alt;
        illegal   = req_alt && !((req_funct3 == 3'b000) || (req_funct3 == 3'b101));
      end
      OP_I: begin
        if (is_shift) begin
          pk.alt  = req_alt;
          pk.imm  = {27'd0, req_imm[4:0]};
          illegal = (req_imm[31:5] != 27'd0) || (req_alt && (req_funct3 == 3'b001));
        end else begin
          illegal = req_alt || !fit12;
        end
      end
      OP_LOAD: begin
        pk.opcode = OPC_LOAD;
        illegal   = req_alt || !fit12 || (req_funct3 == 3'b011) ||
                    (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
      end
      OP_STORE: begin
        pk.opcode = OPC_STORE;
        pk.fmt    = FMT_S;
        illegal   = req_alt || !fit12 || (req_funct3 >= 3'b011);
      end
      OP_BRANCH: begin
        pk.opcode = OPC_BRANCH;
        pk.fmt    = FMT_B;
        illegal   = req_alt || !fit13 || req_imm[0] ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
      end
      OP_JAL: begin
        pk.opcode = OPC_JAL;
        pk.fmt    = FMT_J;
        illegal   = req_alt || !fit21 || req_imm[0];
      end
      OP_JALR: begin
        pk.opcode = OPC_JALR;
        illegal   = req_alt || !fit12 || (req_funct3 != 3'b000);
      end
      OP_LUI: begin
        pk.opcode = OPC_LUI;
        pk.fmt    = FMT_U;
        illegal   = req_alt || !lo_zero;
      end
      OP_AUIPC: begin
        pk.opcode = OPC_AUIPC;
        pk.fmt    = FMT_U;
        illegal   = req_alt || !lo_zero;
      end
      OP_LI: begin
        pk.funct3 = 3'b000;
        pk.rs1    = 5'd0;
        if (req_alt) begin
          illegal = 1'b1;
        end else if (req_rd == 5'd0) begin
          to_nop = 1'b1;
        end else if (!fit12) begin
          if (!LI_SPLIT) begin
            illegal = 1'b1;
          end else begin
            pk.opcode = OPC_LUI;
            pk.fmt    = FMT_U;
            pk.imm    = {li_hi, 12'd0};
            split     = !lo_zero;
          end
        end
      end
      OP_NOP: begin
        illegal = req_alt;
        to_nop  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Second half of a split LI: ADDI rd, rd, imm[11:0].
    pk_addi.opcode = OPC_OP_IMM;
    pk_addi.fmt    = FMT_I;
    pk_addi.funct3 = 3'b000;
    pk_addi.alt    = 1'b0;
    pk_addi.rd     = req_rd;
    pk_addi.rs1    = req_rd;
    pk_addi.rs2    = 5'd0;
    pk_addi.imm    = {20'd0, req_imm[11:0]};

    if (illegal) begin
      first_word = WORD_SUBST;
    end else if (to_nop) begin
      first_word = WORD_NOP;
    end else begin
      first_word = word_pk;
    end
  end

  // Output-stage FSM: next state, next output word and handshake.
  always_comb begin
    state_nxt = state;
    inst_nxt  = inst_o;
    valid_nxt = inst_valid;
    last_nxt  = inst_last;
    err_nxt   = inst_err;
    addi_nxt  = addi_q;
    req_ready = 1'b0;
    accept    = 1'b0;

    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ONE:  req_ready = inst_ready;
      default: req_ready = 1'b0;
    endcase
    accept = req_valid & req_ready;

    case (state)
      ST_FIRST: begin
        if (inst_ready) begin
          state_nxt = ST_ONE;
          inst_nxt  = addi_q;
          valid_nxt = 1'b1;
          last_nxt  = 1'b1;
          err_nxt   = 1'b0;
        end
      end
      default: begin
        // IDLE always moves; ONE moves only once its word is taken
        if ((state == ST_IDLE) || inst_ready) begin
          if (accept) begin
            state_nxt = split ? ST_FIRST : ST_ONE;
            inst_nxt  = first_word;
            valid_nxt = 1'b1;
            last_nxt  = !split;
            err_nxt   = illegal;
            addi_nxt  = word_addi;
          end else begin
            state_nxt = ST_IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      inst_o     <= WORD_NOP;
      inst_valid <= 1'b0;
      inst_last  <= 1'b1;
      inst_err   <= 1'b0;
      addi_q     <= WORD_NOP;
    end else begin
      state      <= state_nxt;
      inst_o     <= inst_nxt;
      inst_valid <= valid_nxt;
      inst_last  <= last_nxt;
      inst_err   <= err_nxt;
      addi_q     <= addi_nxt;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors plus randomized
// requests checked against an encoding model built from the RV32I rules.
module tb_inst_encoder;

  localparam logic [3:0] T_R = 4'd0, T_I = 4'd1, T_LOAD = 4'd2, T_STORE = 4'd3, T_BRANCH = 4'd4,
                         T_JAL = 4'd5, T_JALR = 4'd6, T_LUI = 4'd7, T_AUIPC = 4'd8, T_LI = 4'd9,
                         T_NOP = 4'd10;

  typedef struct packed {
    logic [1:0]  n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_valid2;
  logic        req_ready, req_ready2;
  logic [3:0]  req_op;
  logic [2:0]  req_funct3;
  logic        req_alt;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        inst_valid, inst_valid2;
  logic        inst_ready;
  logic [31:0] inst_o, inst_o2;
  logic        inst_last, inst_last2;
  logic        inst_err, inst_err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_encoder #(.LI_SPLIT(1'b1), .ERR_EBREAK(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_funct3(req_funct3), .req_alt(req_alt), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_o(inst_o), .inst_last(inst_last), .inst_err(inst_err)
  );

  inst_encoder #(.LI_SPLIT(1'b0), .ERR_EBREAK(1'b1)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op), .req_funct3(req_funct3), .req_alt(req_alt), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .inst_valid(inst_valid2),
    .inst_ready(inst_ready), .inst_o(inst_o2), .inst_last(inst_last2), .inst_err(inst_err2)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input bit split_en, input bit ebreak);
    exp_t e;
    longint s;
    bit bad, in12, in13, in21, odd;
    logic [31:0] regs, hi;
    s    = longint'($signed(imm));
    in12 = (s >= -2048) && (s <= 2047);
    in13 = (s >= -4096) && (s <= 4095);
    in21 = (s >= -1048576) && (s <= 1048575);
    odd  = (imm % 2) != 0;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12);
    e.n = 2'd1; e.w0 = 32'h13; e.w1 = 32'h0; e.err = 1'b0; bad = 0;
    case (op)
      T_R: begin
        bad  = alt && (f3 != 0) && (f3 != 5);
        e.w0 = (32'(alt) << 30) | regs | (32'(rd) << 7) | 32'h33;
      end
      T_I: begin
        if (f3 == 1 || f3 == 5) begin
          bad  = (imm > 31) || (f3 == 1 && alt);
          e.w0 = enc_i((imm & 31) | (alt ? 32'd1024 : 32'd0), rs1, f3, rd, 7'h13);
        end else begin
          bad  = alt || !in12;
          e.w0 = enc_i(imm, rs1, f3, rd, 7'h13);
        end
      end
      T_LOAD: begin
        bad  = alt || !in12 || f3 == 3 || f3 == 6 || f3 == 7;
        e.w0 = enc_i(imm, rs1, f3, rd, 7'h03);
      end
      T_STORE: begin
        bad  = alt || !in12 || f3 >= 3;
        e.w0 = (((imm >> 5) & 32'h7F) << 25) | regs | ((imm & 32'h1F) << 7) | 32'h23;
      end
      T_BRANCH: begin
        bad  = alt || !in13 || odd || f3 == 2 || f3 == 3;
        e.w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | regs |
               (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      end
      T_JAL: begin
        bad  = alt || !in21 || odd;
        e.w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
               (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
      end
      T_JALR: begin
        bad  = alt || !in12 || f3 != 0;
        e.w0 = enc_i(imm, rs1, 3'd0, rd, 7'h67);
      end
      T_LUI, T_AUIPC: begin
        bad  = alt || (imm % 4096) != 0;
        e.w0 = imm | (32'(rd) << 7) | ((op == T_LUI) ? 32'h37 : 32'h17);
      end
      T_LI: begin
        if (alt) bad = 1;
        else if (rd == 0) e.w0 = 32'h13;
        else if (in12) e.w0 = enc_i(imm, 5'd0, 3'd0, rd, 7'h13);
        else if (!split_en) bad = 1;
        else begin
          hi   = (imm + 32'h800) >> 12;
          e.w0 = (hi << 12) | (32'(rd) << 7) | 32'h37;
          if ((imm % 4096) != 0) begin
            e.n  = 2'd2;
            e.w1 = enc_i(imm, rd, 3'd0, rd, 7'h13);
          end
        end
      end
      T_NOP: bad = alt;
      default: bad = 1;
    endcase
    if (bad) begin
      e.n = 2'd1; e.err = 1'b1; e.w0 = ebreak ? 32'h00100073 : 32'h13;
    end
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic set_req(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    req_op = op; req_funct3 = f3; req_alt = alt; req_rd = rd;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 0; req_valid2 = 0; inst_ready = 1;
    set_req(T_NOP, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (inst_valid !== 1'b0 || inst_o !== 32'h13 || inst_last !== 1'b1 || inst_err !== 1'b0 ||
        req_ready !== 1'b1 || inst_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b o=%h last=%b err=%b rdy=%b valid2=%b required 0 00000013 1 0 1 0",
               inst_valid, inst_o, inst_last, inst_err, req_ready, inst_valid2);
    end
  endtask

  task automatic test_itype();
    inst_ready = 1;
    set_req(T_I, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5);
    req_valid = 1;
    tick();
    req_valid = 0;
    checks++;
    if (inst_valid !== 1 || inst_o !== 32'h00500093 || inst_last !== 1 || inst_err !== 0) begin
      errors++;
      $display("FAIL itype: valid=%b o=%h last=%b err=%b required 1 00500093 1 0",
               inst_valid, inst_o, inst_last, inst_err);
    end
    tick();
    checks++;
    if (inst_valid !== 0) begin
      errors++; $display("FAIL itype_drain: valid=%b required 0", inst_valid);
    end
  endtask

  task automatic test_li_split();
    inst_ready = 1;
    set_req(T_LI, 3'd7, 0, 5'd5, 5'd3, 5'd4, 32'h12345678);
    req_valid = 1;
    tick();
    req_valid = 0;
    checks++;
    if (inst_valid !== 1 || inst_o !== 32'h123452B7 || inst_last !== 0 || inst_err !== 0 ||
        req_ready !== 0) begin
      errors++;
      $display("FAIL li_lui: valid=%b o=%h last=%b err=%b rdy=%b required 1 123452b7 0 0 0",
               inst_valid, inst_o, inst_last, inst_err, req_ready);
    end
    tick();
    checks++;
    if (inst_valid !== 1 || inst_o !== 32'h67828293 || inst_last !== 1 || req_ready !== 1) begin
      errors++;
      $display("FAIL li_addi: valid=%b o=%h last=%b rdy=%b required 1 67828293 1 1",
               inst_valid, inst_o, inst_last, req_ready);
    end
    // Low 12 bits zero: LUI alone, marked last.
    set_req(T_LI, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    req_valid = 1;
    tick();
    req_valid = 0;
    checks++;
    if (inst_valid !== 1 || inst_o !== 32'h123452B7 || inst_last !== 1) begin
      errors++;
      $display("FAIL li_lui_only: valid=%b o=%h last=%b required 1 123452b7 1",
               inst_valid, inst_o, inst_last);
    end
    tick();
    checks++;
    if (inst_valid !== 0) begin
      errors++; $display("FAIL li_lui_only_drain: valid=%b required 0", inst_valid);
    end
  endtask

  task automatic test_stall();
    inst_ready = 0;
    set_req(T_LI, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
    req_valid = 1;
    tick();
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_valid !== 1 || inst_o !== 32'h123462B7 || inst_last !== 0 || req_ready !== 0) begin
        errors++;
        $display("FAIL stall_lui[%0d]: valid=%b o=%h last=%b rdy=%b required 1 123462b7 0 0",
                 i, inst_valid, inst_o, inst_last, req_ready);
      end
      tick();
    end
    inst_ready = 1;
    tick();
    inst_ready = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_valid !== 1 || inst_o !== 32'hFFF28293 || inst_last !== 1 || inst_err !== 0) begin
        errors++;
        $display("FAIL stall_addi[%0d]: valid=%b o=%h last=%b err=%b required 1 fff28293 1 0",
                 i, inst_valid, inst_o, inst_last, inst_err);
      end
      tick();
    end
    inst_ready = 1;
    tick();
    checks++;
    if (inst_valid !== 0) begin
      errors++; $display("FAIL stall_drain: valid=%b required 0", inst_valid);
    end
  endtask

  task automatic test_branch_jal();
    inst_ready = 1;
    set_req(T_BRANCH, 3'd0, 0, 5'd9, 5'd1, 5'd2, 32'hFFFFFFFC);
    req_valid = 1;
    tick();
    checks++;
    if (inst_o !== 32'hFE208EE3 || inst_err !== 0) begin
      errors++; $display("FAIL branch: o=%h err=%b required fe208ee3 0", inst_o, inst_err);
    end
    set_req(T_JAL, 3'd5, 0, 5'd1, 5'd7, 5'd8, 32'd8);
    tick();
    req_valid = 0;
    checks++;
    if (inst_valid !== 1 || inst_o !== 32'h008000EF || inst_err !== 0) begin
      errors++;
      $display("FAIL jal: valid=%b o=%h err=%b required 1 008000ef 0", inst_valid, inst_o, inst_err);
    end
    tick();
  endtask

  task automatic test_illegal();
    inst_ready = 1;
    set_req(T_BRANCH, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd3);
    req_valid = 1; req_valid2 = 1;
    tick();
    req_valid = 0; req_valid2 = 0;
    checks++;
    if (inst_valid !== 1 || inst_o !== 32'h13 || inst_err !== 1 || inst_last !== 1) begin
      errors++;
      $display("FAIL illegal_nop: valid=%b o=%h err=%b last=%b required 1 00000013 1 1",
               inst_valid, inst_o, inst_err, inst_last);
    end
    checks++;
    if (inst_valid2 !== 1 || inst_o2 !== 32'h00100073 || inst_err2 !== 1) begin
      errors++;
      $display("FAIL illegal_ebreak: valid=%b o=%h err=%b required 1 00100073 1",
               inst_valid2, inst_o2, inst_err2);
    end
    tick();
    // Wide LI without splitting support is illegal.
    set_req(T_LI, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    req_valid2 = 1;
    tick();
    req_valid2 = 0;
    checks++;
    if (inst_valid2 !== 1 || inst_o2 !== 32'h00100073 || inst_err2 !== 1 || inst_last2 !== 1) begin
      errors++;
      $display("FAIL li_nosplit: valid=%b o=%h err=%b last=%b required 1 00100073 1 1",
               inst_valid2, inst_o2, inst_err2, inst_last2);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    logic [31:0] imms [4];
    imms[0] = 32'd1; imms[1] = 32'd2; imms[2] = 32'd3; imms[3] = 32'hFFFFFFFF;
    exp_w[0] = 32'h00100093; exp_w[1] = 32'h00200113;
    exp_w[2] = 32'h00300193; exp_w[3] = 32'hFFF00213;
    inst_ready = 1;
    set_req(T_I, 3'd0, 0, 5'd1, 5'd0, 5'd0, imms[0]);
    req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (inst_valid !== 1 || inst_o !== exp_w[i] || req_ready !== 1) begin
        errors++;
        $display("FAIL b2b[%0d]: valid=%b o=%h rdy=%b required 1 %h 1",
                 i, inst_valid, inst_o, req_ready, exp_w[i]);
      end
      if (i < 3) set_req(T_I, 3'd0, 0, 5'(i + 2), 5'd0, 5'd0, imms[i+1]);
      else req_valid = 0;
    end
    tick();
    checks++;
    if (inst_valid !== 0) begin
      errors++; $display("FAIL b2b_drain: valid=%b required 0", inst_valid);
    end
  endtask

  task automatic test_reset_mid_li();
    inst_ready = 0;
    set_req(T_LI, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    req_valid = 1;
    tick();
    req_valid = 0;
    tick();
    reset_n = 0;
    #1;
    checks++;
    if (inst_valid !== 0 || inst_o !== 32'h13) begin
      errors++;
      $display("FAIL reset_mid_li: valid=%b o=%h required 0 00000013", inst_valid, inst_o);
    end
    tick();
    reset_n = 1;
    inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (inst_valid !== 0 || req_ready !== 1) begin
        errors++;
        $display("FAIL no_addi_after_reset[%0d]: valid=%b rdy=%b o=%h required 0 1",
                 i, inst_valid, req_ready, inst_o);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [31:0] r, imm, want;
    logic [3:0] op;
    logic rdy;
    int k, cyc;
    for (int t = 0; t < 300; t++) begin
      r  = $urandom;
      op = ($urandom_range(0, 9) < 3) ? T_LI : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: imm = {{20{r[11]}}, r[11:0]};
        1: imm = r;
        2: imm = r & 32'hFFFFF000;
        3: imm = r & 32'd31;
        4: imm = {{19{r[12]}}, r[12:1], 1'b0};
        default: imm = {{11{r[20]}}, r[20:0]} & 32'hFFFFFFFE;
      endcase
      set_req(op, 3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              5'($urandom), 5'($urandom), imm);
      e = model(req_op, req_funct3, req_alt, req_rd, req_rs1, req_rs2, req_imm, 1'b1, 1'b0);
      req_valid = 1;
      checks++;
      if (req_ready !== 1) begin
        errors++; $display("FAIL rnd_ready[%0d]: rdy=%b required 1", t, req_ready);
      end
      tick();
      req_valid = 0;
      k = 0; cyc = 0;
      while (k < int'(e.n) && cyc < 40) begin
        want = (k == 0) ? e.w0 : e.w1;
        checks++;
        if (inst_valid !== 1 || inst_o !== want || inst_err !== e.err ||
            inst_last !== (k == int'(e.n) - 1)) begin
          errors++;
          $display("FAIL rnd[%0d] op=%0d imm=%h word%0d: valid=%b o=%h last=%b err=%b required 1 %h %b %b",
                   t, op, imm, k, inst_valid, inst_o, inst_last, inst_err, want,
                   (k == int'(e.n) - 1), e.err);
        end
        if (k == 0 && e.n == 2'd2) begin
          checks++;
          if (req_ready !== 0) begin
            errors++; $display("FAIL rnd_first_ready[%0d]: rdy=%b required 0", t, req_ready);
          end
        end
        rdy = 1'($urandom_range(0, 1));
        inst_ready = rdy;
        tick();
        if (rdy) k++;
        cyc++;
      end
      checks++;
      if (k < int'(e.n) || inst_valid !== 0) begin
        errors++;
        $display("FAIL rnd_done[%0d]: words_seen=%0d valid=%b required %0d 0", t, k, inst_valid, e.n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_li_split();
    test_stall();
    test_branch_jal();
    test_illegal();
    test_back_to_back();
    test_reset_mid_li();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
